// File: rtl/peripheral_uart_tx_if.sv
// Bus interface between the SoC data bus and the UART transmit peripheral.
interface peripheral_uart_tx_if;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [1:0]  addr;
  logic [15:0] d_in;
  logic [15:0] d_out;

  modport master (output cs, output wr, output rd, output addr, output d_in, input d_out);
  modport slave  (input cs, input wr, input rd, input addr, input d_in, output d_out);
endinterface

// File: rtl/peripheral_uart_tx.sv
// Memory-mapped UART transmitter: CPU pushes bytes into a TX FIFO, an 8N1
// serializer drains it LSB-first. STATUS = {overflow, busy, full, empty}.
module peripheral_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_i,
  peripheral_uart_tx_if.slave  bus,
  output logic                 uart_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             status_rd;
  logic             any_rd;
  logic             overflow;
  logic             bit_done;
  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             unused_hi;

  // Only the low byte of the write data carries a character.
  assign unused_hi = ^bus.d_in[15:8];

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push_req  = bus.cs & bus.wr & (bus.addr == 2'd0);
  // Fullness is judged before any same-cycle pop, so a pop never rescues a push.
  assign push      = push_req & ~full;
  assign bit_done  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Pop in IDLE, or on the last STOP cycle so frames run back-to-back.
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign any_rd    = bus.cs & bus.rd;
  assign status_rd = any_rd & (bus.addr == 2'd1);

  // FIFO storage: data only, never reset.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= bus.d_in[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag and one-cycle registered read data.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      overflow  <= 1'b0;
      bus.d_out <= '0;
    end else begin
      if (push_req & full) overflow <= 1'b1;
      else if (status_rd)  overflow <= 1'b0;
      if (status_rd) bus.d_out <= {12'b0, overflow, (state != IDLE), full, empty};
      else           bus.d_out <= '0;
    end
  end

  // 8N1 serializer FSM; uart_tx comes straight from a flop.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          clk_cnt <= '0;
          bit_idx <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          if (bit_done) begin
            clk_cnt <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          uart_tx <= shift[0];
          if (bit_done) begin
            clk_cnt <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (bit_done) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_uart_tx.sv
// Directed bench for peripheral_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_peripheral_uart_tx;

  logic sys_clk_i = 1'b0;
  logic sys_rst_i = 1'b0;
  logic uart_tx;

  peripheral_uart_tx_if bus ();

  peripheral_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .bus       (bus.slave),
    .uart_tx   (uart_tx)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    string       nm;
  } vec_t;

  vec_t vecs [10];

  // Receiver monitor state
  logic       rx_en   = 1'b0;
  logic       rx_prev = 1'b1;
  logic [7:0] rx_byte;
  int         rx_err  = 0;
  logic [7:0] rx_q [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    tick();
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] v);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    tick();
    bus.cs = 1'b0; bus.rd = 1'b0;
    v = bus.d_out;
  endtask

  // Checks one 40-cycle frame, starting at the first start-bit sample.
  task automatic check_frame(input logic [7:0] b, input string nm);
    logic e;
    logic ok;
    for (int k = 0; k < 10; k++) begin
      e  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (uart_tx !== e) ok = 1'b0;
        tick();
      end
      chk($sformatf("%s_bit%0d", nm, k), {15'b0, ok}, 16'h0001);
    end
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(posedge sys_clk_i);
      #2;
    end
  endtask

  // Mid-bit sampling receiver used where frames overlap bus activity.
  always begin : rx_mon
    mon_wait(1);
    if (rx_en && rx_prev && !uart_tx) begin
      mon_wait(2);
      if (uart_tx !== 1'b0) rx_err++;
      for (int i = 0; i < 8; i++) begin
        mon_wait(4);
        rx_byte[i] = uart_tx;
      end
      mon_wait(4);
      if (uart_tx !== 1'b1) rx_err++;
      rx_q.push_back(rx_byte);
      rx_prev = uart_tx;
    end else begin
      rx_prev = uart_tx;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] v;
    int lows;

    bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = 2'd0; bus.d_in = 16'h0;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, "rd_data"};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd1, 16'h00AB, 16'h0000, "wr_status"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0012, 16'h0000, "wr_rsv2"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0034, 16'h0000, "wr_rsv3"};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h0077, 16'h0000, "wr_nocs"};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0001, "rd_status"};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd2, 16'h0000, 16'h0000, "rd_rsv2"};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h0000, 16'h0000, "rd_rsv3"};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000, "rd_nocs"};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, "idle"};

    // 1: reset
    sys_rst_i = 1'b0;
    repeat (5) tick();
    chk("rst_tx", {15'b0, uart_tx}, 16'h0001);
    chk("rst_dout", bus.d_out, 16'h0000);
    sys_rst_i = 1'b1;
    tick();
    chk("idle_dout", bus.d_out, 16'h0000);
    bus_read(2'd1, v);
    chk("rst_status", v, 16'h0001);
    tick();
    chk("rd_hold_once", bus.d_out, 16'h0000);

    // 2: single byte 0x55
    bus_write(2'd0, 16'h0055);
    tick();
    chk("t2_pre_start", {15'b0, uart_tx}, 16'h0001);
    tick();
    check_frame(8'h55, "t2");
    bus_read(2'd1, v);
    chk("t2_status", v, 16'h0001);

    // 3: back-to-back frames
    bus_write(2'd0, 16'h00A5);
    bus_write(2'd0, 16'h003C);
    tick();
    check_frame(8'hA5, "t3a");
    check_frame(8'h3C, "t3b");
    chk("t3_idle_after", {15'b0, uart_tx}, 16'h0001);

    // 4: overflow
    rx_q.delete();
    rx_err = 0;
    rx_en  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = 2'd0; bus.d_in = 16'(i);
      tick();
    end
    bus.cs = 1'b0; bus.wr = 1'b0;
    bus_read(2'd1, v);
    chk("t4_status_ovf", v, 16'h000E);
    bus_read(2'd1, v);
    chk("t4_status_clr", v, 16'h0006);
    repeat (370) tick();
    rx_en = 1'b0;
    chk("t4_rx_count", 16'(rx_q.size()), 16'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) chk($sformatf("t4_rx%0d", i), {8'h00, rx_q[i]}, 16'(i + 1));
      else chk($sformatf("t4_rx%0d", i), 16'hFFFF, 16'(i + 1));
    end
    chk("t4_frame_err", 16'(rx_err), 16'd0);
    bus_read(2'd1, v);
    chk("t4_status_end", v, 16'h0001);

    // 5: reset mid-frame
    bus_write(2'd0, 16'h00FF);
    bus_write(2'd0, 16'h0000);
    tick();
    chk("t5_start", {15'b0, uart_tx}, 16'h0000);
    repeat (16) tick();
    sys_rst_i = 1'b0;
    tick();
    chk("t5_tx_after_rst", {15'b0, uart_tx}, 16'h0001);
    chk("t5_dout_rst", bus.d_out, 16'h0000);
    sys_rst_i = 1'b1;
    lows = 0;
    repeat (100) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    chk("t5_no_start", 16'(lows), 16'd0);
    bus_read(2'd1, v);
    chk("t5_status", v, 16'h0001);

    // 6: bus decode table
    for (int i = 0; i < 10; i++) begin
      bus.cs = vecs[i].cs; bus.wr = vecs[i].wr; bus.rd = vecs[i].rd;
      bus.addr = vecs[i].addr; bus.d_in = vecs[i].din;
      tick();
      bus.cs = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
      chk(vecs[i].nm, bus.d_out, vecs[i].exp_dout);
      tick();
      chk({vecs[i].nm, "_next"}, bus.d_out, 16'h0000);
    end
    repeat (4) tick();
    chk("t6_tx_idle", {15'b0, uart_tx}, 16'h0001);
    bus_read(2'd1, v);
    chk("t6_status", v, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
